alu_wb: RTL and testbench

Writeback stage behind the 16-bit ALU. It accepts ALU results, destination indices and SVNZC flags over a valid/ready handshake and buffers them in a small FIFO toward the register-file write port. It keeps the architectural status register and evaluates 4-bit branch conditions from it. It sits between the ALU output (y, s, v, n, z, c) and the register file and branch unit.

---
 rtl/alu_wb_if.sv | 44 ++++
 rtl/alu_wb.sv | 154 +++++++++++++++
 tb/tb_alu_wb.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_wb_if.sv
// ---------------------------------------------------------------------------
// alu_wb_if
// Handshake bundle between the ALU output, the writeback FIFO and the
// register-file write port.
//
//   in_valid   ALU result valid                (master -> slave)
//   in_ready   writeback stage can accept      (slave  -> master)
//   in_data    ALU result y                    (master -> slave)
//   in_flags   {s,v,n,z,c} produced by the ALU (master -> slave)
//   in_rd      destination register index      (master -> slave)
//   in_setf    load status register on accept  (master -> slave)
//   out_valid  writeback entry available       (slave  -> master)
//   out_ready  register file takes the entry   (master -> slave)
//   out_data   head entry data                 (slave  -> master)
//   out_rd     head entry destination          (slave  -> master)
//
// The master modport is the environment around the stage (ALU on the
// input side, register file on the output side); slave is alu_wb itself.
// ---------------------------------------------------------------------------
interface alu_wb_if #(
    parameter int DATA_W = 16,
    parameter int RD_W   = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [4:0]        in_flags;
    logic [RD_W-1:0]   in_rd;
    logic              in_setf;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [RD_W-1:0]   out_rd;

    modport master (
        output in_valid, in_data, in_flags, in_rd, in_setf, out_ready,
        input  in_ready, out_valid, out_data, out_rd
    );

    modport slave (
        input  in_valid, in_data, in_flags, in_rd, in_setf, out_ready,
        output in_ready, out_valid, out_data, out_rd
    );
endinterface

// File: rtl/alu_wb.sv
// ---------------------------------------------------------------------------
// alu_wb
// Writeback stage behind the 16-bit ALU. Buffers ALU results and their
// destination indices in a DEPTH-entry FIFO toward the register-file write
// port, keeps the architectural status register {s,v,n,z,c} and evaluates
// the 4-bit branch condition against it.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   resetn     asynchronous active-low reset
//   bus        alu_wb_if.slave: in_* push side, out_* pop side
//   flush      synchronous FIFO clear (status register untouched)
//   status     committed {s,v,n,z,c}
//   cond       branch condition selector
//   cond_true  selected condition holds on status (combinational)
//   count      FIFO occupancy, 0..DEPTH
//
// Optional feature (macro QN_ALU_WB_BYPASS_EN):
//   defined   - when the FIFO is empty an incoming entry is presented on
//               out_* in the same cycle; if it is taken it never enters
//               the FIFO.
//   undefined - out_valid comes from FIFO state only; push-to-out latency
//               is always one cycle.
// ---------------------------------------------------------------------------
module alu_wb #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2,
    parameter int RD_W   = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    alu_wb_if.slave                  bus,
    input  logic                     flush,
    output logic [4:0]               status,
    input  logic [3:0]               cond,
    output logic                     cond_true,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Branch condition evaluation on a {s,v,n,z,c} flag vector.
    function automatic logic cond_eval(input logic [3:0] sel, input logic [4:0] f);
        logic s, v, n, z, c;
        logic r;
        s = f[4];
        v = f[3];
        n = f[2];
        z = f[1];
        c = f[0];
        case (sel)
            4'h0:    r = 1'b1;
            4'h1:    r = z;
            4'h2:    r = !z;
            4'h3:    r = c;
            4'h4:    r = !c;
            4'h5:    r = n;
            4'h6:    r = !n;
            4'h7:    r = v;
            4'h8:    r = !v;
            4'h9:    r = !z && (n == v);
            4'hA:    r = (n == v);
            4'hB:    r = (n != v);
            4'hC:    r = z || (n != v);
            4'hD:    r = s;
            4'hE:    r = !s;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [RD_W-1:0]   mem_rd   [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;

    logic empty;
    logic full;
    logic accept;    // handshake completes on the input side
    logic store;     // accepted entry is written into the FIFO
    logic pop;       // head entry leaves the FIFO
    logic byp_take;  // accepted entry consumed directly by the bypass

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // in_ready looks at occupancy only, so a full FIFO does not accept in
    // the same cycle it pops.
    assign bus.in_ready = !full;

    // A push coinciding with flush is dropped, including its flag update.
    assign accept = bus.in_valid && !full && !flush;

`ifdef QN_ALU_WB_BYPASS_EN
    logic byp_vld;
    assign byp_vld       = empty && bus.in_valid && !flush;
    assign byp_take      = byp_vld && bus.out_ready;
    assign bus.out_valid = (!empty && !flush) || byp_vld;
    assign bus.out_data  = byp_vld ? bus.in_data : mem_data[rptr];
    assign bus.out_rd    = byp_vld ? bus.in_rd   : mem_rd[rptr];
`else
    assign byp_take      = 1'b0;
    assign bus.out_valid = !empty && !flush;
    assign bus.out_data  = mem_data[rptr];
    assign bus.out_rd    = mem_rd[rptr];
`endif

    assign store = accept && !byp_take;
    assign pop   = !empty && bus.out_ready && !flush;

    assign cond_true = cond_eval(cond, status);

    // FIFO state, storage and status register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            status <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_rd[i]   <= '0;
            end
        end else begin
            if (flush) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (store) begin
                    mem_data[wptr] <= bus.in_data;
                    mem_rd[wptr]   <= bus.in_rd;
                    wptr           <= wptr + PTR_W'(1);
                end
                if (pop) begin
                    rptr <= rptr + PTR_W'(1);
                end
                case ({store, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end

            // Flags commit at accept time, independent of when the entry pops.
            if (accept && bus.in_setf) begin
                status <= bus.in_flags;
            end
        end
    end

endmodule

// File: tb/tb_alu_wb.sv
// ---------------------------------------------------------------------------
// tb_alu_wb
// Directed self-checking bench for alu_wb (DATA_W=16, DEPTH=2, RD_W=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled a
// further time unit later, well away from the active edge.
// ---------------------------------------------------------------------------
module tb_alu_wb;

    logic       clk;
    logic       resetn;
    logic       flush;
    logic [4:0] status;
    logic [3:0] cond;
    logic       cond_true;
    logic [1:0] count;

    int n_assert;
    int n_fail;

    logic [15:0] cond_exp;

    alu_wb_if #(.DATA_W(16), .RD_W(4)) bus ();

    alu_wb #(.DATA_W(16), .DEPTH(2), .RD_W(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus.slave),
        .flush     (flush),
        .status    (status),
        .cond      (cond),
        .cond_true (cond_true),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d, input logic [3:0] rd,
                        input logic [4:0] fl, input logic setf);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_rd    = rd;
        bus.in_flags = fl;
        bus.in_setf  = setf;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_data  = 16'h0000;
        bus.in_rd    = 4'h0;
        bus.in_flags = 5'b00000;
        bus.in_setf  = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        resetn   = 1'b0;
        flush    = 1'b0;
        cond     = 4'h0;
        bus.out_ready = 1'b0;
        idle();
        #2;

        // Reset state
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data",  32'(bus.out_data),  32'h0);
        check("rst_out_rd",    32'(bus.out_rd),    32'h0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_count",     32'(count),         32'd0);
        check("rst_status",    32'(status),        32'h0);
        check("rst_cond0",     32'(cond_true),     32'd1);
        resetn = 1'b1;
        step();

        // Reset mid-traffic
        push(16'hAAAA, 4'h1, 5'b11111, 1'b1);
        step();
        push(16'hBBBB, 4'h2, 5'b11111, 1'b1);
        step();
        idle();
        #1;
        check("mid_count_full", 32'(count),        32'd2);
        check("mid_in_ready0",  32'(bus.in_ready), 32'd0);
        check("mid_status_set", 32'(status),       32'h1F);
        #1;
        resetn = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_count",     32'(count),         32'd0);
        check("arst_status",    32'(status),        32'h0);
        check("arst_in_ready",  32'(bus.in_ready),  32'd1);
        resetn = 1'b1;
        push(16'h0003, 4'h3, 5'b00000, 1'b0);
        step();
        idle();
        #1;
        check("post_rst_valid", 32'(bus.out_valid), 32'd1);
        check("post_rst_data",  32'(bus.out_data),  32'h0003);
        check("post_rst_rd",    32'(bus.out_rd),    32'h3);
        check("post_rst_count", 32'(count),         32'd1);
        bus.out_ready = 1'b1;
        step();
        check("post_rst_alone", 32'(bus.out_valid), 32'd0);
        check("post_rst_cnt0",  32'(count),         32'd0);

        // Backpressure
        bus.out_ready = 1'b0;
        push(16'h0007, 4'h7, 5'b00000, 1'b0);
        step();
        push(16'h8000, 4'h8, 5'b00000, 1'b0);
        step();
        push(16'hA5A5, 4'hA, 5'b00000, 1'b0);
        #1;
        check("bp_in_ready0",  32'(bus.in_ready), 32'd0);
        step();
        check("bp_held_count", 32'(count),        32'd2);
        check("bp_held_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        #1;
        check("bp_head0", 32'(bus.out_data), 32'h0007);
        check("bp_rd0",   32'(bus.out_rd),   32'h7);
        step();
        check("bp_head1",    32'(bus.out_data), 32'h8000);
        check("bp_cnt_pop",  32'(count),        32'd1);
        check("bp_ready_up", 32'(bus.in_ready), 32'd1);
        step();
        idle();
        #1;
        check("bp_head2",  32'(bus.out_data), 32'hA5A5);
        check("bp_rd2",    32'(bus.out_rd),   32'hA);
        check("bp_cnt_pp", 32'(count),        32'd1);
        step();
        check("bp_drained", 32'(bus.out_valid), 32'd0);

        // Flags and branch conditions
        bus.out_ready = 1'b0;
        push(16'h8001, 4'h1, 5'b10100, 1'b1);
        #1;
        check("fl_before_edge", 32'(status), 32'h00);
        step();
        idle();
        check("fl_status", 32'(status), 32'h14);
        cond_exp = 16'h3935;
        for (int i = 0; i < 16; i++) begin
            cond = 4'(i);
            #1;
            check($sformatf("cond_%0h", i), 32'(cond_true), 32'(cond_exp[i]));
        end
        cond = 4'h0;
        push(16'h4444, 4'h4, 5'b00010, 1'b0);
        step();
        idle();
        check("fl_setf0_keep", 32'(status), 32'h14);
        bus.out_ready = 1'b1;
        #1;
        check("fl_head0", 32'(bus.out_data), 32'h8001);
        step();
        check("fl_head1", 32'(bus.out_data), 32'h4444);
        step();
        check("fl_drained", 32'(count), 32'd0);

        // Concurrent push and pop at count=1
        bus.out_ready = 1'b0;
        push(16'h5555, 4'h5, 5'b00000, 1'b0);
        step();
        push(16'h1111, 4'h1, 5'b00000, 1'b0);
        bus.out_ready = 1'b1;
        step();
        idle();
        check("cc_count", 32'(count),        32'd1);
        check("cc_head",  32'(bus.out_data), 32'h1111);
        step();
        check("cc_drain", 32'(count),        32'd0);

        // Flush with a simultaneous push
        bus.out_ready = 1'b0;
        push(16'h6666, 4'h6, 5'b00000, 1'b0);
        step();
        push(16'h2222, 4'h2, 5'b11111, 1'b1);
        flush = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check("fls_valid_low", 32'(bus.out_valid), 32'd0);
        step();
        flush = 1'b0;
        idle();
        #1;
        check("fls_count",  32'(count),         32'd0);
        check("fls_valid",  32'(bus.out_valid), 32'd0);
        check("fls_status", 32'(status),        32'h14);
        step();
        check("fls_no_2222", 32'(bus.out_valid), 32'd0);

        // Bypass behaviour on an empty FIFO with out_ready=1
        bus.out_ready = 1'b1;
        push(16'h1234, 4'h5, 5'b00000, 1'b0);
        #1;
`ifdef QN_ALU_WB_BYPASS_EN
        check("byp_same_valid", 32'(bus.out_valid), 32'd1);
        check("byp_same_data",  32'(bus.out_data),  32'h1234);
        check("byp_same_rd",    32'(bus.out_rd),    32'h5);
        step();
        idle();
        check("byp_count0",     32'(count),         32'd0);
        check("byp_no_repeat",  32'(bus.out_valid), 32'd0);
`else
        check("nobyp_same_valid", 32'(bus.out_valid), 32'd0);
        step();
        idle();
        check("nobyp_valid", 32'(bus.out_valid), 32'd1);
        check("nobyp_data",  32'(bus.out_data),  32'h1234);
        check("nobyp_count", 32'(count),         32'd1);
        step();
        check("nobyp_drain", 32'(count),         32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
